// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style pipeline blocks.
//   - aluc_e      : ALU control codes driven on EALUC
//   - ALUC_BUBBLE : op driven by an empty slot (ADD, with no side effects)
//   - REG_ZERO    : index of the hard-wired zero register
//   - *_DEF       : default datapath, register-index and ALU-control widths
package mips_pkg;

  localparam int DW_DEF = 32;
  localparam int RW_DEF = 5;
  localparam int CW_DEF = 4;

  typedef enum logic [3:0] {
    ALUC_AND  = 4'b0000,
    ALUC_OR   = 4'b0001,
    ALUC_ADD  = 4'b0010,
    ALUC_ADDU = 4'b0011,
    ALUC_JAL  = 4'b0100,
    ALUC_SLTU = 4'b0101,
    ALUC_SUB  = 4'b0110,
    ALUC_SLT  = 4'b0111,
    ALUC_SLL  = 4'b1000,
    ALUC_SRL  = 4'b1001,
    ALUC_NOR  = 4'b1010,
    ALUC_XOR  = 4'b1100,
    ALUC_SUBU = 4'b1110,
    ALUC_LUI  = 4'b1111
  } aluc_e;

  localparam aluc_e ALUC_BUBBLE = ALUC_ADD;
  localparam logic [RW_DEF-1:0] REG_ZERO = '0;

endpackage

// File: rtl/fwd_mux.sv
// EX-stage operand forwarding for one source register.
//   src_idx              : source register index held in ID/EX
//   reg_val              : register-file value captured with it
//   mem_regwrite/dst/alu : EX/MEM writeback (newest, wins)
//   wb_regwrite/dst/data : MEM/WB writeback
//   fwd_val              : operand presented to EX
// r0 is never forwarded: it always reads its captured value.
module fwd_mux #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic [RW-1:0] src_idx,
  input  logic [DW-1:0] reg_val,
  input  logic          mem_regwrite,
  input  logic [RW-1:0] mem_dst,
  input  logic [DW-1:0] mem_alu,
  input  logic          wb_regwrite,
  input  logic [RW-1:0] wb_dst,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] fwd_val
);

  always_comb begin
    fwd_val = reg_val;
    if (src_idx != '0) begin
      if (mem_regwrite && (mem_dst == src_idx)) begin
        fwd_val = mem_alu;
      end else if (wb_regwrite && (wb_dst == src_idx)) begin
        fwd_val = wb_data;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the EX-stage ALU.
//   clk, rst         : clock and synchronous active-high reset
//   id_*             : decoded instruction from ID
//   flush, hold      : kill the entering instruction / freeze ID/EX
//   mem_*, wb_*      : EX/MEM and MEM/WB writeback for forwarding
//   EALUC, EXA, EXB  : ALU control and operands
//   ex_store_data    : forwarded rt for stores
//   ex_dst, ex_valid, ex_memread, ex_memwrite, ex_regwrite : registered control
//   stall            : load-use hazard, freeze PC and IF/ID
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [CW-1:0] id_aluc,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_dst,
  input  logic [DW-1:0] id_rs_val,
  input  logic [DW-1:0] id_rt_val,
  input  logic [DW-1:0] id_imm,
  input  logic          id_alusrc,
  input  logic          id_memread,
  input  logic          id_memwrite,
  input  logic          id_regwrite,
  input  logic          flush,
  input  logic          hold,
  input  logic          mem_regwrite,
  input  logic [RW-1:0] mem_dst,
  input  logic [DW-1:0] mem_alu,
  input  logic          wb_regwrite,
  input  logic [RW-1:0] wb_dst,
  input  logic [DW-1:0] wb_data,
  output logic [CW-1:0] EALUC,
  output logic [DW-1:0] EXA,
  output logic [DW-1:0] EXB,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_dst,
  output logic          ex_valid,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_regwrite,
  output logic          stall
);

  localparam logic [CW-1:0] AlucBubble = CW'(ALUC_BUBBLE);

  logic          valid_q,    valid_d;
  logic [CW-1:0] aluc_q,     aluc_d;
  logic [RW-1:0] rs_q,       rs_d;
  logic [RW-1:0] rt_q,       rt_d;
  logic [RW-1:0] dst_q,      dst_d;
  logic [DW-1:0] rs_val_q,   rs_val_d;
  logic [DW-1:0] rt_val_q,   rt_val_d;
  logic [DW-1:0] imm_q,      imm_d;
  logic          alusrc_q,   alusrc_d;
  logic          memread_q,  memread_d;
  logic          memwrite_q, memwrite_d;
  logic          regwrite_q, regwrite_d;

  logic          id_uses_rt;
  logic          load_use;
  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;

  // Stores read rt even though EXB takes the immediate.
  assign id_uses_rt = !id_alusrc || id_memwrite;

  assign load_use = valid_q && memread_q && (dst_q != '0) &&
                    ((dst_q == id_rs) || ((dst_q == id_rt) && id_uses_rt));

  // A flushed ID instruction is dead, so it cannot cause a stall.
  assign stall = id_valid && !flush && load_use;

  always_comb begin
    valid_d    = valid_q;
    aluc_d     = aluc_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    dst_d      = dst_q;
    rs_val_d   = rs_val_q;
    rt_val_d   = rt_val_q;
    imm_d      = imm_q;
    alusrc_d   = alusrc_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    regwrite_d = regwrite_q;
    if (flush || (!hold && stall)) begin
      valid_d    = 1'b0;
      aluc_d     = AlucBubble;
      rs_d       = '0;
      rt_d       = '0;
      dst_d      = '0;
      rs_val_d   = '0;
      rt_val_d   = '0;
      imm_d      = '0;
      alusrc_d   = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
      regwrite_d = 1'b0;
    end else if (!hold) begin
      valid_d    = id_valid;
      aluc_d     = id_aluc;
      rs_d       = id_rs;
      rt_d       = id_rt;
      dst_d      = id_dst;
      rs_val_d   = id_rs_val;
      rt_val_d   = id_rt_val;
      imm_d      = id_imm;
      alusrc_d   = id_alusrc;
      memread_d  = id_memread  && id_valid;
      memwrite_d = id_memwrite && id_valid;
      regwrite_d = id_regwrite && id_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      aluc_q     <= AlucBubble;
      rs_q       <= '0;
      rt_q       <= '0;
      dst_q      <= '0;
      rs_val_q   <= '0;
      rt_val_q   <= '0;
      imm_q      <= '0;
      alusrc_q   <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      regwrite_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      aluc_q     <= aluc_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      dst_q      <= dst_d;
      rs_val_q   <= rs_val_d;
      rt_val_q   <= rt_val_d;
      imm_q      <= imm_d;
      alusrc_q   <= alusrc_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      regwrite_q <= regwrite_d;
    end
  end

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
    .src_idx      (rs_q),
    .reg_val      (rs_val_q),
    .mem_regwrite (mem_regwrite),
    .mem_dst      (mem_dst),
    .mem_alu      (mem_alu),
    .wb_regwrite  (wb_regwrite),
    .wb_dst       (wb_dst),
    .wb_data      (wb_data),
    .fwd_val      (fwd_rs)
  );

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
    .src_idx      (rt_q),
    .reg_val      (rt_val_q),
    .mem_regwrite (mem_regwrite),
    .mem_dst      (mem_dst),
    .mem_alu      (mem_alu),
    .wb_regwrite  (wb_regwrite),
    .wb_dst       (wb_dst),
    .wb_data      (wb_data),
    .fwd_val      (fwd_rt)
  );

  assign EALUC         = aluc_q;
  assign EXA           = fwd_rs;
  assign EXB           = alusrc_q ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ex_dst        = dst_q;
  assign ex_valid      = valid_q;
  assign ex_memread    = memread_q;
  assign ex_memwrite   = memwrite_q;
  assign ex_regwrite   = regwrite_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  import mips_pkg::*;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [3:0]  id_aluc;
  logic [4:0]  id_rs, id_rt, id_dst;
  logic [31:0] id_rs_val, id_rt_val, id_imm;
  logic        id_alusrc, id_memread, id_memwrite, id_regwrite;
  logic        flush, hold;
  logic        mem_regwrite;
  logic [4:0]  mem_dst;
  logic [31:0] mem_alu;
  logic        wb_regwrite;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;
  logic [3:0]  EALUC;
  logic [31:0] EXA, EXB, ex_store_data;
  logic [4:0]  ex_dst;
  logic        ex_valid, ex_memread, ex_memwrite, ex_regwrite, stall;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [3:0]  aluc;
    logic [31:0] exa, exb, sd;
    logic [4:0]  dst;
    logic        v, mr, mw, rw, st;
  } exp_t;

  exp_t  sb[$];
  string tag_q[$];

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_aluc(id_aluc), .id_rs(id_rs), .id_rt(id_rt),
    .id_dst(id_dst), .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
    .id_imm(id_imm), .id_alusrc(id_alusrc), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_regwrite(id_regwrite),
    .flush(flush), .hold(hold),
    .mem_regwrite(mem_regwrite), .mem_dst(mem_dst), .mem_alu(mem_alu),
    .wb_regwrite(wb_regwrite), .wb_dst(wb_dst), .wb_data(wb_data),
    .EALUC(EALUC), .EXA(EXA), .EXB(EXB), .ex_store_data(ex_store_data),
    .ex_dst(ex_dst), .ex_valid(ex_valid), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_regwrite(ex_regwrite), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string fld,
                     input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
  endtask

  task automatic push(input string tag, input logic [3:0] aluc,
                      input logic [31:0] exa, input logic [31:0] exb,
                      input logic [31:0] sd, input logic [4:0] dst,
                      input logic v, input logic mr, input logic mw,
                      input logic rw, input logic st);
    exp_t e;
    e.aluc = aluc; e.exa = exa; e.exb = exb; e.sd = sd; e.dst = dst;
    e.v = v; e.mr = mr; e.mw = mw; e.rw = rw; e.st = st;
    sb.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic compare();
    exp_t  e;
    string t;
    if (sb.size() == 0) begin
      n_checks++;
      $error("FAIL scoreboard_empty observed=0 expected=nonzero");
    end else begin
      e = sb.pop_front();
      t = tag_q.pop_front();
      chk(t, "EALUC",  {28'd0, EALUC},        {28'd0, e.aluc});
      chk(t, "EXA",    EXA,                   e.exa);
      chk(t, "EXB",    EXB,                   e.exb);
      chk(t, "store",  ex_store_data,         e.sd);
      chk(t, "dst",    {27'd0, ex_dst},       {27'd0, e.dst});
      chk(t, "valid",  {31'd0, ex_valid},     {31'd0, e.v});
      chk(t, "memrd",  {31'd0, ex_memread},   {31'd0, e.mr});
      chk(t, "memwr",  {31'd0, ex_memwrite},  {31'd0, e.mw});
      chk(t, "regwr",  {31'd0, ex_regwrite},  {31'd0, e.rw});
      chk(t, "stall",  {31'd0, stall},        {31'd0, e.st});
    end
  endtask

  task automatic set_id(input logic v, input logic [3:0] aluc,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] dst, input logic [31:0] rsv,
                        input logic [31:0] rtv, input logic [31:0] imm,
                        input logic alusrc, input logic mr, input logic mw,
                        input logic rw);
    id_valid = v; id_aluc = aluc; id_rs = rs; id_rt = rt; id_dst = dst;
    id_rs_val = rsv; id_rt_val = rtv; id_imm = imm; id_alusrc = alusrc;
    id_memread = mr; id_memwrite = mw; id_regwrite = rw;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; hold = 1'b0;
    set_id(0, ALUC_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mem_regwrite = 0; mem_dst = 0; mem_alu = 0;
    wb_regwrite = 0;  wb_dst = 0;  wb_data = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    push("reset", 4'b0010, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    compare();
    rst = 1'b0;

    // add r10 = r8 + r3; r8 then forwarded from EX/MEM over MEM/WB
    set_id(1, ALUC_ADD, 8, 3, 10, 32'd5, 32'd7, 0, 0, 0, 0, 1);
    tick();
    mem_regwrite = 1; mem_dst = 8; mem_alu = 32'h100;
    wb_regwrite = 1;  wb_dst = 8;  wb_data = 32'h200;
    push("fwd_mem", 4'b0010, 32'h100, 32'd7, 32'd7, 10, 1, 0, 0, 1, 0);
    #1 compare();
    mem_dst = 9;
    push("fwd_wb", 4'b0010, 32'h200, 32'd7, 32'd7, 10, 1, 0, 0, 1, 0);
    #1 compare();
    mem_regwrite = 0; wb_regwrite = 0;
    push("fwd_none", 4'b0010, 32'd5, 32'd7, 32'd7, 10, 1, 0, 0, 1, 0);
    #1 compare();

    // r0 guard
    set_id(1, ALUC_ADD, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    tick();
    mem_regwrite = 1; mem_dst = 0; mem_alu = 32'hDEAD;
    wb_regwrite = 1;  wb_dst = 0;  wb_data = 32'hBEEF;
    push("r0_guard", 4'b0010, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    #1 compare();
    mem_regwrite = 0; wb_regwrite = 0;

    // lw r9, 4(r2) then dependent add r11 = r9 + r4
    set_id(1, ALUC_ADD, 2, 9, 9, 32'h40, 0, 32'd4, 1, 1, 0, 1);
    tick();
    push("lw_in_ex", 4'b0010, 32'h40, 32'd4, 0, 9, 1, 1, 0, 1, 0);
    compare();
    set_id(1, ALUC_ADD, 9, 4, 11, 32'd1, 32'd2, 0, 0, 0, 0, 1);
    push("lu_stall", 4'b0010, 32'h40, 32'd4, 0, 9, 1, 1, 0, 1, 1);
    #1 compare();
    tick();
    push("lu_bubble", 4'b0010, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    compare();
    tick();
    push("lu_load", 4'b0010, 32'd1, 32'd2, 32'd2, 11, 1, 0, 0, 1, 0);
    compare();

    // sll r12 with immediate; rt=9 forwarded to store data only
    set_id(1, ALUC_SLL, 0, 9, 12, 0, 32'd3, 32'h100, 1, 0, 0, 1);
    tick();
    mem_regwrite = 1; mem_dst = 9; mem_alu = 32'h55;
    push("sll_imm", 4'b1000, 0, 32'h100, 32'h55, 12, 1, 0, 0, 1, 0);
    #1 compare();
    mem_regwrite = 0;

    // lw r5, 8(r1); flush kills the dependent instruction
    set_id(1, ALUC_ADD, 1, 5, 5, 32'd10, 0, 32'd8, 1, 1, 0, 1);
    tick();
    push("lw2", 4'b0010, 32'd10, 32'd8, 0, 5, 1, 1, 0, 1, 0);
    compare();
    set_id(1, ALUC_ADD, 5, 6, 13, 32'd3, 32'd4, 0, 0, 0, 0, 1);
    flush = 1;
    push("flush_gate", 4'b0010, 32'd10, 32'd8, 0, 5, 1, 1, 0, 1, 0);
    #1 compare();
    tick();
    push("flush_bubble", 4'b0010, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    compare();
    flush = 0;

    // reload lw r5, then hold with a pending load-use
    set_id(1, ALUC_ADD, 1, 5, 5, 32'd10, 0, 32'd8, 1, 1, 0, 1);
    tick();
    push("lw3", 4'b0010, 32'd10, 32'd8, 0, 5, 1, 1, 0, 1, 0);
    compare();
    set_id(1, ALUC_ADD, 5, 6, 13, 32'd3, 32'd4, 0, 0, 0, 0, 1);
    hold = 1;
    push("hold_stall", 4'b0010, 32'd10, 32'd8, 0, 5, 1, 1, 0, 1, 1);
    #1 compare();
    for (int i = 0; i < 3; i++) begin
      tick();
      push("hold_cyc", 4'b0010, 32'd10, 32'd8, 0, 5, 1, 1, 0, 1, 1);
      compare();
    end
    // sw r5 uses rt even with alusrc
    set_id(1, ALUC_ADD, 0, 5, 0, 0, 0, 32'd4, 1, 0, 1, 0);
    push("sw_stall", 4'b0010, 32'd10, 32'd8, 0, 5, 1, 1, 0, 1, 1);
    #1 compare();
    set_id(0, ALUC_ADD, 5, 6, 13, 32'd3, 32'd4, 0, 0, 0, 0, 1);
    push("invalid_nostall", 4'b0010, 32'd10, 32'd8, 0, 5, 1, 1, 0, 1, 0);
    #1 compare();
    hold = 0;
    set_id(1, ALUC_SUB, 6, 7, 13, 32'd3, 32'd4, 0, 0, 0, 0, 1);
    push("release_id", 4'b0010, 32'd10, 32'd8, 0, 5, 1, 1, 0, 1, 0);
    #1 compare();
    tick();
    push("release_load", 4'b0110, 32'd3, 32'd4, 32'd4, 13, 1, 0, 0, 1, 0);
    compare();

    // invalid slot: fields load, control bits masked
    set_id(0, ALUC_SUB, 1, 2, 14, 32'd5, 32'd6, 0, 0, 1, 1, 1);
    tick();
    push("invalid_ctl", 4'b0110, 32'd5, 32'd6, 32'd6, 14, 0, 0, 0, 0, 0);
    compare();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
